// File: rtl/button_pkg.sv
// Shared constants and helpers for the push-button conditioning block.
package button_pkg;

  // System clock the default debounce window is derived from.
  localparam int unsigned CLK_HZ = 50_000_000;

  // Settling time a button must show before a new level is believed.
  localparam int unsigned DEBOUNCE_MS = 10;

  // 10 ms at 50 MHz = 500000 cycles.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

  // Bits needed to hold values 0 .. value-1. Callers pass value >= 2,
  // so the result is always at least 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned n;
    if (value <= 1) begin
      return 0;
    end
    v = value - 1;
    n = 0;
    while (v != 0) begin
      n++;
      v = v >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One button channel: 2-FF synchronizer, polarity normalisation, saturating
// debounce counter, registered level and one-cycle press/release pulses.
module debounce_bit
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned          CNT_W    = clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // A released button reads 1 on an active-low pin, 0 otherwise.
  localparam logic                 IDLE_PIN = ACTIVE_LOW;

  logic             sync1_q;
  logic             sync2_q;
  logic             sample;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             level_q,   level_d;
  logic             press_q,   press_d;
  logic             release_q, release_d;

  // Bring the asynchronous pin into clk; reset to the idle pin level so a
  // released button does not look like a pending change after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= IDLE_PIN;
      sync2_q <= IDLE_PIN;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Normalise after the synchronizer: 1 means pressed regardless of wiring.
  assign sample = sync2_q ^ ACTIVE_LOW;

  // Count consecutive cycles of disagreement with the accepted level; any
  // agreement clears the count, so glitches and bounce restart the window.
  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sample == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d     = '0;
      level_d   = sample;
      press_d   = sample;
      release_d = ~sample;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounce state and registered outputs; pulses change on the same edge
  // as the level so downstream edge capture sees them aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Conditions the raw board push-buttons for the button PIO in_port: one
// independent debounce channel per button, outputs active-high.
module button_debouncer
  import button_pkg::*;
#(
  parameter int          WIDTH           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  // One channel per button; the buses are just the channel bits side by side.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_bit (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn_raw_i (btn_raw[i]),
      .level_o   (btn_level[i]),
      .press_o   (press_pulse[i]),
      .release_o (release_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer with a 4-cycle debounce window.
module tb_button_debouncer;

  localparam int W = 3;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] btn_raw;
  logic [W-1:0] btn_level;
  logic [W-1:0] press_pulse;
  logic [W-1:0] release_pulse;

  int unsigned  cyc;
  int           checks;
  int           errors;

  typedef struct {
    string       name;
    int unsigned at;
    logic [W-1:0] level;
    logic [W-1:0] press;
    logic [W-1:0] rel;
  } exp_t;

  exp_t exp_q[$];

  button_debouncer #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (4),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input string nm, input int unsigned at,
                           input logic [W-1:0] l, input logic [W-1:0] p,
                           input logic [W-1:0] r);
    exp_t e;
    e.name = nm; e.at = at; e.level = l; e.press = p; e.rel = r;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset(input string nm);
    checks++;
    if (btn_level !== '0 || press_pulse !== '0 || release_pulse !== '0) begin
      errors++;
      $display("FAIL %s cyc=%0d got level=%b press=%b release=%b, need all 0",
               nm, cyc, btn_level, press_pulse, release_pulse);
    end
  endtask

  // Monitor: any level change or pulse is an output event and must match
  // the next expected event, including the cycle it occurs in.
  initial begin
    logic [W-1:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        prev = btn_level;
      end else if (btn_level !== prev || press_pulse !== '0 || release_pulse !== '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d level=%b press=%b release=%b",
                   cyc, btn_level, press_pulse, release_pulse);
        end else begin
          e = exp_q.pop_front();
          if (e.at != cyc || btn_level !== e.level || press_pulse !== e.press ||
              release_pulse !== e.rel) begin
            errors++;
            $display("FAIL %s got cyc=%0d level=%b press=%b release=%b, need cyc=%0d level=%b press=%b release=%b",
                     e.name, cyc, btn_level, press_pulse, release_pulse,
                     e.at, e.level, e.press, e.rel);
          end
        end
        prev = btn_level;
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    btn_raw = 3'b010;

    // Reset with buttons 0 and 2 held.
    repeat (3) begin
      @(negedge clk); #1;
      check_reset("reset_hold");
    end
    @(negedge clk); reset_n = 1'b1;
    expect_ev("reset_accept", cyc + 6, 3'b101, 3'b101, 3'b000);
    step(8);

    @(negedge clk); btn_raw = 3'b111;
    expect_ev("release_02", cyc + 6, 3'b000, 3'b000, 3'b101);
    step(8);

    // Clean press and release of button 0.
    @(negedge clk); btn_raw = 3'b110;
    expect_ev("press_0", cyc + 6, 3'b001, 3'b001, 3'b000);
    step(8);
    @(negedge clk); btn_raw = 3'b111;
    expect_ev("release_0", cyc + 6, 3'b000, 3'b000, 3'b001);
    step(8);

    // 3-cycle glitch on button 1: one short of acceptance.
    @(negedge clk); btn_raw = 3'b101;
    step(3); btn_raw = 3'b111;
    step(10);

    // Bounce on button 2, then a stable press.
    @(negedge clk); btn_raw = 3'b011;
    step(2); btn_raw = 3'b111;
    step(2); btn_raw = 3'b011;
    step(2); btn_raw = 3'b111;
    step(2); btn_raw = 3'b011;
    expect_ev("bounce_press_2", cyc + 6, 3'b100, 3'b100, 3'b000);
    step(10);

    // Press the other two, then release all together.
    @(negedge clk); btn_raw = 3'b000;
    expect_ev("press_01", cyc + 6, 3'b111, 3'b011, 3'b000);
    step(8);
    @(negedge clk); btn_raw = 3'b111;
    expect_ev("release_all", cyc + 6, 3'b000, 3'b000, 3'b111);
    step(8);

    // Reset two cycles into a count on button 0, held through reset.
    @(negedge clk); btn_raw = 3'b110;
    step(4); reset_n = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      check_reset("reset_midcount");
    end
    @(negedge clk); reset_n = 1'b1;
    expect_ev("reset_reaccept", cyc + 6, 3'b001, 3'b001, 3'b000);
    step(8);
    @(negedge clk); btn_raw = 3'b111;
    expect_ev("final_release_0", cyc + 6, 3'b000, 3'b000, 3'b001);
    step(10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got %0d outstanding, need 0 (next %s)",
               exp_q.size(), exp_q[0].name);
    end
    checks++;
    if (btn_level !== 3'b000) begin
      errors++;
      $display("FAIL final_level got %b, need 000", btn_level);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
